// File: rtl/serial_pattern_gen_pkg.sv
// Shared definitions for the serial pattern transmitter.
// State encodings and default widths.
package serial_pattern_gen_pkg;

  localparam int MAX_LEN_DEF = 8;
  localparam int LEN_W_DEF   = 4;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_SEND = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/serial_pattern_gen_shreg.sv
// Load/shift register with down-counting bit counter.
// Keeps a copy of the pattern so repetitions can reload it.
module pattern_shreg #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               reload,
  input  logic               shift,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               msb,
  output logic               last
);

  logic [MAX_LEN-1:0] sr;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt;
  logic [LEN_W-1:0]   pad_in;
  logic [LEN_W-1:0]   pad_q;

  // Left-align so the first bit always sits in the top position
  assign pad_in = LEN_W'(MAX_LEN) - len;
  assign pad_q  = LEN_W'(MAX_LEN) - len_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sr    <= '0;
      pat_q <= '0;
      len_q <= '0;
      cnt   <= '0;
    end else if (load) begin
      sr    <= pattern << pad_in;
      pat_q <= pattern;
      len_q <= len;
      cnt   <= len;
    end else if (reload) begin
      sr  <= pat_q << pad_q;
      cnt <= len_q;
    end else if (shift) begin
      sr  <= sr << 1;
      cnt <= cnt - LEN_W'(1);
    end
  end

  assign msb  = sr[MAX_LEN-1];
  assign last = (cnt == LEN_W'(1));

endmodule

// File: rtl/serial_pattern_gen.sv
// Serial bit-pattern transmitter for the sequence detectors.
// Sends a latched pattern MSB-first, optionally repeated.
module serial_pattern_gen
  import serial_pattern_gen_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int LEN_W   = LEN_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   length,
  input  logic [LEN_W-1:0]   reps,
  output logic               w_out,
  output logic               valid,
  output logic               busy,
  output logic               done
);

  logic [1:0]       state;
  logic [LEN_W-1:0] reps_left;
  logic [LEN_W-1:0] len_c;
  logic             go;
  logic             nz;
  logic             in_send;
  logic             rep_more;
  logic             msb;
  logic             last;
  logic             load;
  logic             reload;
  logic             shift;

  assign len_c    = (length > LEN_W'(MAX_LEN)) ?
                    LEN_W'(MAX_LEN) : length;
  assign nz       = (len_c != '0) && (reps != '0);
  assign go       = (state == ST_IDLE) && start && !abort;
  assign in_send  = (state == ST_SEND);
  assign rep_more = (reps_left > LEN_W'(1));
  assign load     = go && nz;
  assign reload   = in_send && !abort && last && rep_more;
  assign shift    = in_send && !abort;

  pattern_shreg #(
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W)
  ) u_shreg (
    .clock  (clock),
    .reset  (reset),
    .load   (load),
    .reload (reload),
    .shift  (shift),
    .pattern(pattern),
    .len    (len_c),
    .msb    (msb),
    .last   (last)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      reps_left <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (go) begin
            state     <= nz ? ST_SEND : ST_DONE;
            reps_left <= reps;
          end
        end
        ST_SEND: begin
          if (abort) begin
            state <= ST_IDLE;
          end else if (last) begin
            if (rep_more) begin
              reps_left <= reps_left - LEN_W'(1);
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Held low outside SEND so the detector never sees stale 1s
  assign w_out = in_send & msb;
  assign valid = in_send;
  assign busy  = (state != ST_IDLE);
  assign done  = (state == ST_DONE);

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Bench for serial_pattern_gen: directed scenarios plus random
// traffic against a queue-based stream model.
module tb_serial_pattern_gen;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] length = '0;
  logic [3:0] reps = '0;
  logic       w_out;
  logic       valid;
  logic       busy;
  logic       done;

  int n_vec = 0;
  int n_err = 0;

  // Each entry is the expected {w_out, valid, busy, done} of one cycle
  logic [3:0] exp_q[$];

  always #5 clock = ~clock;

  serial_pattern_gen dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .abort  (abort),
    .pattern(pattern),
    .length (length),
    .reps   (reps),
    .w_out  (w_out),
    .valid  (valid),
    .busy   (busy),
    .done   (done)
  );

  always @(posedge clock) begin : model
    int len_l;
    if (reset) begin
      exp_q.delete();
    end else if (exp_q.size() == 0) begin
      if (start && !abort) begin
        len_l = (length > 4'd8) ? 8 : int'(length);
        for (int r = 0; r < int'(reps); r++)
          for (int i = len_l - 1; i >= 0; i--)
            exp_q.push_back({pattern[3'(i)], 3'b110});
        exp_q.push_back(4'b0011);
      end
    end else if (exp_q[0][2] && abort) begin
      exp_q.delete();
    end else begin
      void'(exp_q.pop_front());
    end
  end

  task automatic check(input string tag,
                       input logic [3:0] got,
                       input logic [3:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: {w,valid,busy,done} got %b expected %b at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic tick(input string tag);
    logic [3:0] e;
    @(negedge clock);
    e = (exp_q.size() == 0) ? 4'b0000 : exp_q[0];
    check(tag, {w_out, valid, busy, done}, e);
  endtask

  task automatic drive(input logic st, input logic ab,
                       input logic [7:0] pat,
                       input logic [3:0] len,
                       input logic [3:0] rp);
    start   = st;
    abort   = ab;
    pattern = pat;
    length  = len;
    reps    = rp;
  endtask

  // Scramble data inputs while start stays low
  task automatic noise();
    drive(1'b0, 1'b0, 8'($urandom), 4'($urandom), 4'($urandom));
  endtask

  initial begin
    tick("reset");
    tick("reset");
    reset = 1'b0;
    tick("idle");

    drive(1'b1, 1'b0, 8'h0D, 4'd4, 4'd1);
    tick("basic");
    noise();
    repeat (6) tick("basic");

    drive(1'b1, 1'b0, 8'h0F, 4'd4, 4'd2);
    tick("repeat");
    noise();
    repeat (10) tick("repeat");

    drive(1'b1, 1'b0, 8'hA5, 4'd12, 4'd1);
    tick("clamp");
    noise();
    repeat (10) tick("clamp");

    drive(1'b1, 1'b0, 8'hFF, 4'd0, 4'd3);
    tick("degen_len");
    noise();
    repeat (3) tick("degen_len");
    drive(1'b1, 1'b0, 8'hFF, 4'd5, 4'd0);
    tick("degen_reps");
    noise();
    repeat (3) tick("degen_reps");

    drive(1'b1, 1'b0, 8'hB7, 4'd4, 4'd1);
    tick("abort");
    noise();
    tick("abort");
    abort = 1'b1;
    tick("abort");
    drive(1'b1, 1'b0, 8'h09, 4'd4, 4'd1);
    tick("restart");
    noise();
    repeat (6) tick("restart");

    drive(1'b1, 1'b1, 8'hFF, 4'd4, 4'd1);
    tick("abort_start");
    noise();
    repeat (2) tick("abort_start");

    drive(1'b1, 1'b0, 8'hFF, 4'd6, 4'd2);
    tick("reset_mid");
    noise();
    tick("reset_mid");
    reset = 1'b1;
    tick("reset_mid");
    reset = 1'b0;
    repeat (2) tick("reset_mid");

    drive(1'b1, 1'b0, 8'h0D, 4'd4, 4'd2);
    tick("start_busy");
    drive(1'b1, 1'b0, 8'hF0, 4'd8, 4'd3);
    repeat (5) tick("start_busy");
    noise();
    repeat (8) tick("start_busy");

    repeat (3000) begin
      tick("rand");
      start   = ($urandom_range(0, 5) == 0);
      abort   = ($urandom_range(0, 30) == 0);
      reset   = ($urandom_range(0, 150) == 0);
      pattern = 8'($urandom);
      length  = 4'($urandom_range(0, 15));
      reps    = 4'($urandom_range(0, 3));
    end
    reset = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    repeat (30) tick("drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
